// File: rtl/timing_gen.sv
// timing_gen: free-running bit-time (1..29) and word-time (0..WORDS-1) generator.
// Optional macro G15_CT_MATCH_EN adds the CMD_T input and the registered CT match.
module timing_gen #(
  parameter int WORDS = 108
) (
  input  logic       CLOCK,
  input  logic       rst,
`ifdef G15_CT_MATCH_EN
  input  logic [6:0] CMD_T,
`endif
  output logic [4:0] BT,
  output logic [6:0] WT,
  output logic       T1,
  output logic       T2,
  output logic       T29,
  output logic       TE,
  output logic       TL,
  output logic       CT
);

  localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);
  localparam logic [4:0] LAST_BIT  = 5'd29;

  logic       run_q, run_d;
  logic [4:0] bit_q, bit_d;
  logic [6:0] word_q, word_d;
  logic       t1_q, t1_d;
  logic       t2_q, t2_d;
  logic       t29_q, t29_d;
  logic       te_q, te_d;
  logic       tl_q, tl_d;

  // Next counter state; strobes decode that next state so outputs are pure flops.
  always_comb begin
    run_d  = 1'b1;
    bit_d  = 5'd1;
    word_d = 7'd0;
    if (!run_q) begin
      bit_d  = 5'd1;
      word_d = 7'd0;
    end else if (bit_q == LAST_BIT) begin
      bit_d = 5'd1;
      if (word_q == LAST_WORD) begin
        word_d = 7'd0;
      end else begin
        word_d = word_q + 7'd1;
      end
    end else begin
      bit_d  = bit_q + 5'd1;
      word_d = word_q;
    end
    t1_d  = (bit_d == 5'd1);
    t2_d  = (bit_d == 5'd2);
    t29_d = (bit_d == LAST_BIT);
    te_d  = ~word_d[0];
    tl_d  = (bit_d == LAST_BIT) && (word_d == LAST_WORD);
  end

  // Counter and strobe registers; run_q absorbs a release coincident with an edge.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      run_q  <= 1'b0;
      bit_q  <= 5'd0;
      word_q <= 7'd0;
      t1_q   <= 1'b0;
      t2_q   <= 1'b0;
      t29_q  <= 1'b0;
      te_q   <= 1'b0;
      tl_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      bit_q  <= bit_d;
      word_q <= word_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      t29_q  <= t29_d;
      te_q   <= te_d;
      tl_q   <= tl_d;
    end
  end

  assign BT  = bit_q;
  assign WT  = word_q;
  assign T1  = t1_q;
  assign T2  = t2_q;
  assign T29 = t29_q;
  assign TE  = te_q;
  assign TL  = tl_q;

`ifdef G15_CT_MATCH_EN
  logic [6:0] ct_q, ct_d;
  logic       match_q, match_d;

  // CMD_T is captured on the T29 edge; the match is re-evaluated only at word start.
  always_comb begin
    if (bit_d == LAST_BIT) begin
      ct_d = CMD_T;
    end else begin
      ct_d = ct_q;
    end
    if (bit_d == 5'd1) begin
      match_d = (word_d == ct_q);
    end else begin
      match_d = match_q;
    end
  end

  // Comparator registers; 127 in reset so the first word after release never matches.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      ct_q    <= 7'd127;
      match_q <= 1'b0;
    end else begin
      ct_q    <= ct_d;
      match_q <= match_d;
    end
  end

  assign CT = match_q;
`else
  assign CT = 1'b0;
`endif

endmodule

// File: tb/tb_timing_gen.sv
// Scoreboard bench for timing_gen: two instances (WORDS=108 and WORDS=5) against an
// edge-count reference model; CT expectations apply when G15_CT_MATCH_EN is defined.
module tb_timing_gen;

  typedef struct packed {
    logic [4:0] bt;
    logic [6:0] wt;
    logic       t1;
    logic       t2;
    logic       t29;
    logic       te;
    logic       tl;
    logic       ct;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  localparam int WA = 108;
  localparam int WB = 5;
`ifdef G15_CT_MATCH_EN
  localparam bit CT_EN = 1'b1;
`else
  localparam bit CT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cmd = 7'd7;

  logic [4:0] a_bt, b_bt;
  logic [6:0] a_wt, b_wt;
  logic       a_t1, a_t2, a_t29, a_te, a_tl, a_ct;
  logic       b_t1, b_t2, b_t29, b_te, b_tl, b_ct;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n = 0;
  int   pending = 127;
  int   match = 127;
  bit   finish_req = 1'b0;
  bit   guard_expired = 1'b0;

  always #5 clk = ~clk;

  timing_gen #(.WORDS(WA)) dut_a (
    .CLOCK(clk), .rst(rst_n),
`ifdef G15_CT_MATCH_EN
    .CMD_T(cmd),
`endif
    .BT(a_bt), .WT(a_wt), .T1(a_t1), .T2(a_t2), .T29(a_t29),
    .TE(a_te), .TL(a_tl), .CT(a_ct)
  );

  timing_gen #(.WORDS(WB)) dut_b (
    .CLOCK(clk), .rst(rst_n),
`ifdef G15_CT_MATCH_EN
    .CMD_T(cmd),
`endif
    .BT(b_bt), .WT(b_wt), .T1(b_t1), .T2(b_t2), .T29(b_t29),
    .TE(b_te), .TL(b_tl), .CT(b_ct)
  );

  // Expected outputs after nn counted edges (nn = 0 means in/just out of reset).
  function automatic obs_t model(input int nn, input int w, input int m);
    obs_t o;
    int   b;
    int   wd;
    o = '0;
    if (nn > 0) begin
      b     = ((nn - 1) % 29) + 1;
      wd    = ((nn - 1) / 29) % w;
      o.bt  = 5'(b);
      o.wt  = 7'(wd);
      o.t1  = (b == 1);
      o.t2  = (b == 2);
      o.t29 = (b == 29);
      o.te  = ((wd % 2) == 0);
      o.tl  = (b == 29) && (wd == w - 1);
      o.ct  = CT_EN && (wd == m);
    end
    return o;
  endfunction

  // One clock: advance the model for the edge, then apply mid-cycle stimulus and push.
  task automatic tick(input logic rst_val, input logic [6:0] cmd_val);
    logic       rst_prev;
    logic [6:0] cmd_prev;
    int         b;
    exp_t       e;
    rst_prev = rst_n;
    cmd_prev = cmd;
    @(posedge clk);
    if (rst_prev) begin
      n++;
      b = ((n - 1) % 29) + 1;
      if (b == 29) pending = int'(cmd_prev);
      if (b == 1) match = pending;
    end
    #2;
    rst_n = rst_val;
    cmd   = cmd_val;
    if (!rst_val) begin
      n       = 0;
      pending = 127;
      match   = 127;
    end
    e.a = model(n, WA, match);
    e.b = model(n, WB, match);
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s n=%0d: got bt=%0d wt=%0d t1,t2,t29,te,tl,ct=%b%b%b%b%b%b want bt=%0d wt=%0d t1,t2,t29,te,tl,ct=%b%b%b%b%b%b",
               name, n, got.bt, got.wt, got.t1, got.t2, got.t29, got.te, got.tl, got.ct,
               want.bt, want.wt, want.t1, want.t2, want.t29, want.te, want.tl, want.ct);
    end
  endtask

  // Monitor: pops one expectation per cycle, compares both DUTs, and closes the run.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("dut_w108", {a_bt, a_wt, a_t1, a_t2, a_t29, a_te, a_tl, a_ct}, e.a);
      check("dut_w5", {b_bt, b_wt, b_t1, b_t2, b_t29, b_te, b_tl, b_ct}, e.b);
    end
    if (finish_req) begin
      n_cmp++;
      if (guard_expired) begin
        n_bad++;
        $display("FAIL reset_point_search: got timeout, want word 3 bit 16 reached");
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_bad++;
        $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    int cur;
    int len;
    int guard;
    cur = 7;
    repeat (3) tick(1'b0, 7'd7);
    tick(1'b1, 7'd7);

    // Full revolution of the 108-word instance plus wrap; CMD_T 7, then 9, then 120.
    for (int i = 0; i < 3300; i++) begin
      if (n + 1 == 8 * 29 + 10) cur = 9;
      else if (n + 1 == 12 * 29 + 5) cur = 120;
      tick(1'b1, 7'(cur));
    end

    // Reset asserted mid-cycle during word 3, bit 17 of the 108-word instance.
    guard = 0;
    while (!((((n - 1) % 29) + 1 == 16) && ((((n - 1) / 29) % WA) == 3)) && guard < 29 * WA + 29) begin
      tick(1'b1, 7'(cur));
      guard++;
    end
    guard_expired = (guard >= 29 * WA + 29);
    tick(1'b0, 7'(cur));
    repeat (2) tick(1'b0, 7'(cur));
    tick(1'b1, 7'(cur));

    // Randomized run lengths, CMD_T changes and reset pulses.
    for (int s = 0; s < 30; s++) begin
      len = int'($urandom_range(600, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(15, 0) == 0) begin
          if ($urandom_range(3, 0) == 0) cur = int'($urandom_range(127, 0));
          else cur = int'($urandom_range(11, 0));
        end
        tick(1'b1, 7'(cur));
      end
      repeat (int'($urandom_range(3, 1))) tick(1'b0, 7'(cur));
      tick(1'b1, 7'(cur));
    end
    finish_req = 1'b1;
  end

endmodule
